// File: rtl/sample_deserializer_if.sv
// rtl/sample_deserializer_if.sv - frame output handshake bundle
interface sample_deserializer_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/sample_deserializer.sv
// rtl/sample_deserializer.sv - byte-strobe deserializer assembling MSB-first multi-channel frames
module sample_deserializer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_raw,
  input  logic [7:0]             byte_in,
  sample_deserializer_if.master  frame,
  output logic                   overflow,
  output logic                   timeout_err,
  output logic [2:0]             byte_idx
);
  localparam int W      = NUM_CHANNELS * DATA_WIDTH;
  localparam int NBYTES = W / 8;
  localparam int CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]    LAST_IDX = 3'(NBYTES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, ASSEMBLING} state_t;

  state_t        state;
  logic          wr_s1, wr_s2, wr_prev, armed;
  logic [1:0]    fill;
  logic [7:0]    byte_s1, byte_s2;
  logic [W-1:0]  asm_q, hold_q;
  logic          valid_q;
  logic [CW-1:0] idle_cnt;

  logic          capture, last, consume;
  logic [W-1:0]  shifted, completed;

  // Edge detection is only armed once a genuine low level has passed the
  // synchroniser, so a strobe held high across reset is ignored.
  assign capture   = armed & wr_s2 & ~wr_prev;
  assign last      = (byte_idx == LAST_IDX);
  assign consume   = valid_q & frame.frame_ready;
  assign shifted   = {{(W-8){1'b0}}, byte_s2} << (8 * (NBYTES - 1 - int'(byte_idx)));
  assign completed = asm_q | {{(W-8){1'b0}}, byte_s2};

  assign frame.frame_data  = hold_q;
  assign frame.frame_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_s1       <= 1'b0;
      wr_s2       <= 1'b0;
      wr_prev     <= 1'b0;
      armed       <= 1'b0;
      fill        <= 2'b00;
      byte_s1     <= 8'h00;
      byte_s2     <= 8'h00;
      asm_q       <= '0;
      hold_q      <= '0;
      valid_q     <= 1'b0;
      idle_cnt    <= '0;
      byte_idx    <= 3'd0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_s1       <= wr_en_raw;
      wr_s2       <= wr_s1;
      wr_prev     <= wr_s2;
      fill        <= {fill[0], 1'b1};
      byte_s1     <= byte_in;
      byte_s2     <= byte_s1;
      timeout_err <= 1'b0;
      if (fill[1] && !wr_s2) armed <= 1'b1;
      if (consume) valid_q <= 1'b0;

      if (capture) begin
        idle_cnt <= '0;
        if (last) begin
          byte_idx <= 3'd0;
          asm_q    <= '0;
          state    <= IDLE;
          if (!valid_q || frame.frame_ready) begin
            hold_q  <= completed;
            valid_q <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + 3'd1;
          asm_q    <= asm_q | shifted;
          state    <= ASSEMBLING;
        end
      end else if (state == ASSEMBLING) begin
        if (idle_cnt == TO_LAST) begin
          timeout_err <= 1'b1;
          byte_idx    <= 3'd0;
          asm_q       <= '0;
          idle_cnt    <= '0;
          state       <= IDLE;
        end else begin
          idle_cnt <= idle_cnt + CNT_ONE;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sample_deserializer.sv
// tb/tb_sample_deserializer.sv - directed self-checking bench for sample_deserializer
module tb_sample_deserializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_raw;
  logic [7:0] byte_in;
  logic       overflow;
  logic       timeout_err;
  logic [2:0] byte_idx;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  int pulse_at;

  sample_deserializer_if #(.WIDTH(64)) fif ();

  sample_deserializer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_raw   (wr_en_raw),
    .byte_in     (byte_in),
    .frame       (fif),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .byte_idx    (byte_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_en_raw = 1'b1;
    byte_in   = b;
    tick();
    wr_en_raw = 1'b0;
    tick();
  endtask

  // Sends all eight bytes; the final capture lands on the following edge.
  task automatic send_frame_bytes(input logic [63:0] f);
    for (int k = 0; k < 8; k++) send_byte(f[63-8*k -: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  fif.frame_data, 64'h0);
    check({tag, "_valid"}, 64'(fif.frame_valid), 64'h0);
    check({tag, "_ovf"},   64'(overflow), 64'h0);
    check({tag, "_to"},    64'(timeout_err), 64'h0);
    check({tag, "_idx"},   64'(byte_idx), 64'h0);
  endtask

  initial begin
    rst             = 1'b1;
    wr_en_raw       = 1'b0;
    byte_in         = 8'h00;
    fif.frame_ready = 1'b1;
    ticks(3);
    check_all_zero("reset");
    rst = 1'b0;
    ticks(4);

    // Basic frame with downstream always ready
    send_frame_bytes(64'h0001_0002_0003_0004);
    check("basic_pre_valid", 64'(fif.frame_valid), 64'h0);
    tick();
    check("basic_valid", 64'(fif.frame_valid), 64'h1);
    check("basic_data", fif.frame_data, 64'h0001_0002_0003_0004);
    check("basic_ch0", 64'(fif.frame_data[15:0]), 64'h0004);
    check("basic_idx", 64'(byte_idx), 64'h0);
    tick();
    check("basic_valid_drop", 64'(fif.frame_valid), 64'h0);

    // Strobe held high for 10 cycles captures one byte
    wr_en_raw = 1'b1;
    byte_in   = 8'hAA;
    ticks(10);
    wr_en_raw = 1'b0;
    ticks(3);
    check("held_idx", 64'(byte_idx), 64'h1);

    // Two more bytes, then idle into timeout
    send_byte(8'hBB);
    send_byte(8'hCC);
    tick();
    check("partial_idx", 64'(byte_idx), 64'h3);
    pulses   = 0;
    pulse_at = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (timeout_err) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("timeout_pulses", 64'(pulses), 64'h1);
    check("timeout_at", 64'(pulse_at), 64'd64);
    check("timeout_idx", 64'(byte_idx), 64'h0);
    check("timeout_valid", 64'(fif.frame_valid), 64'h0);

    send_frame_bytes(64'h1122_3344_5566_7788);
    tick();
    check("post_to_valid", 64'(fif.frame_valid), 64'h1);
    check("post_to_data", fif.frame_data, 64'h1122_3344_5566_7788);
    tick();

    // Overflow: downstream stalled across two frames
    fif.frame_ready = 1'b0;
    send_frame_bytes(64'hA0A1_A2A3_A4A5_A6A7);
    tick();
    check("ovf_first_valid", 64'(fif.frame_valid), 64'h1);
    check("ovf_first_data", fif.frame_data, 64'hA0A1_A2A3_A4A5_A6A7);
    send_frame_bytes(64'hB0B1_B2B3_B4B5_B6B7);
    check("ovf_before", 64'(overflow), 64'h0);
    tick();
    check("ovf_set", 64'(overflow), 64'h1);
    check("ovf_valid", 64'(fif.frame_valid), 64'h1);
    check("ovf_held_data", fif.frame_data, 64'hA0A1_A2A3_A4A5_A6A7);
    fif.frame_ready = 1'b1;
    tick();
    check("ovf_consumed", 64'(fif.frame_valid), 64'h0);
    check("ovf_sticky", 64'(overflow), 64'h1);

    // Reset mid-frame with the strobe held high through reset release
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k));
    tick();
    check("mid_idx", 64'(byte_idx), 64'h5);
    wr_en_raw = 1'b1;
    byte_in   = 8'h55;
    rst       = 1'b1;
    ticks(2);
    check_all_zero("midrst");
    rst = 1'b0;
    ticks(10);
    check("held_thru_rst_idx", 64'(byte_idx), 64'h0);
    wr_en_raw = 1'b0;
    ticks(4);
    send_frame_bytes(64'h0102_0304_0506_0708);
    tick();
    check("after_rst_valid", 64'(fif.frame_valid), 64'h1);
    check("after_rst_data", fif.frame_data, 64'h0102_0304_0506_0708);
    tick();

    // Consume and complete on the same edge
    fif.frame_ready = 1'b0;
    send_frame_bytes(64'hD0D1_D2D3_D4D5_D6D7);
    tick();
    check("sim_first_data", fif.frame_data, 64'hD0D1_D2D3_D4D5_D6D7);
    send_frame_bytes(64'hE0E1_E2E3_E4E5_E6E7);
    fif.frame_ready = 1'b1;
    tick();
    check("sim_valid", 64'(fif.frame_valid), 64'h1);
    check("sim_data", fif.frame_data, 64'hE0E1_E2E3_E4E5_E6E7);
    check("sim_ovf", 64'(overflow), 64'h0);
    tick();
    check("sim_drained", 64'(fif.frame_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
